// File: rtl/wb_regfile_pkg.sv
// Shared types and constants for the write-back register file (wb_regfile, hilo_reg).
// Optional macro WB_BYPASS_EN enables same-cycle forwarding of write-back data to the outputs.
package wb_regfile_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int REG_NUM = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] reg_bus_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam logic      RST_ACTIVE   = 1'b0;
    localparam reg_bus_t  ZERO_WORD    = '0;
    localparam reg_addr_t NOP_REG_ADDR = '0;
    localparam logic      WRITE_ENABLE = 1'b1;
    localparam logic      READ_ENABLE  = 1'b1;

    // $0 is hardwired zero, so a write aimed at it must never land.
    function automatic logic gpr_write_hit(input logic we, input reg_addr_t wd);
        return (we == WRITE_ENABLE) && (wd != NOP_REG_ADDR);
    endfunction

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair, always written together; forwards write data when WB_BYPASS_EN is defined.
module hilo_reg
    import wb_regfile_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     we,
    input  reg_bus_t wr_hi,
    input  reg_bus_t wr_lo,
    output reg_bus_t hi,
    output reg_bus_t lo
);

    reg_bus_t hi_q;
    reg_bus_t lo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            hi_q <= ZERO_WORD;
            lo_q <= ZERO_WORD;
        end else if (we == WRITE_ENABLE) begin
            hi_q <= wr_hi;
            lo_q <= wr_lo;
        end
    end

    // Forwarding is gated by reset so the outputs read zero while reset is held.
    always_comb begin
        hi = hi_q;
        lo = lo_q;
`ifdef WB_BYPASS_EN
        if (rst != RST_ACTIVE && we == WRITE_ENABLE) begin
            hi = wr_hi;
            lo = wr_lo;
        end
`endif
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back sink: commits GPR, HI/LO and LLbit state; two combinational GPR read ports.
// Optional macro WB_BYPASS_EN forwards same-cycle write-back data to all outputs.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  reg_bus_t  wb_wdata,
    input  reg_addr_t wb_wd,
    input  logic      wb_wreg,
    input  reg_bus_t  wb_hi,
    input  reg_bus_t  wb_lo,
    input  logic      wb_whilo,
    input  logic      wb_LLbit_we,
    input  logic      wb_LLbit_value,
    input  logic      flush,
    input  logic      re1,
    input  reg_addr_t raddr1,
    output reg_bus_t  rdata1,
    input  logic      re2,
    input  reg_addr_t raddr2,
    output reg_bus_t  rdata2,
    output reg_bus_t  hi_o,
    output reg_bus_t  lo_o,
    output logic      LLbit_o
);

    reg_bus_t gpr [REG_NUM];
    logic     llbit;
    logic     wr_hit;

    assign wr_hit = gpr_write_hit(wb_wreg, wb_wd);

    // Entry 0 is cleared on reset and never written, so it always reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                gpr[i] <= ZERO_WORD;
            end
        end else if (wr_hit) begin
            gpr[wb_wd] <= wb_wdata;
        end
    end

    // A flush kills any pending LL/SC reservation, even one being set this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            llbit <= 1'b0;
        end else if (flush) begin
            llbit <= 1'b0;
        end else if (wb_LLbit_we == WRITE_ENABLE) begin
            llbit <= wb_LLbit_value;
        end
    end

    always_comb begin
        rdata1 = ZERO_WORD;
        if (rst != RST_ACTIVE && re1 == READ_ENABLE && raddr1 != NOP_REG_ADDR) begin
            rdata1 = gpr[raddr1];
`ifdef WB_BYPASS_EN
            if (wr_hit && raddr1 == wb_wd) begin
                rdata1 = wb_wdata;
            end
`endif
        end
    end

    always_comb begin
        rdata2 = ZERO_WORD;
        if (rst != RST_ACTIVE && re2 == READ_ENABLE && raddr2 != NOP_REG_ADDR) begin
            rdata2 = gpr[raddr2];
`ifdef WB_BYPASS_EN
            if (wr_hit && raddr2 == wb_wd) begin
                rdata2 = wb_wdata;
            end
`endif
        end
    end

    always_comb begin
        LLbit_o = llbit;
`ifdef WB_BYPASS_EN
        if (rst == RST_ACTIVE || flush) begin
            LLbit_o = 1'b0;
        end else if (wb_LLbit_we == WRITE_ENABLE) begin
            LLbit_o = wb_LLbit_value;
        end
`endif
    end

    hilo_reg u_hilo_reg (
        .clk   (clk),
        .rst   (rst),
        .we    (wb_whilo),
        .wr_hi (wb_hi),
        .wr_lo (wb_lo),
        .hi    (hi_o),
        .lo    (lo_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations follow WB_BYPASS_EN when defined.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_wdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        wb_LLbit_we;
    logic        wb_LLbit_value;
    logic        flush;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        LLbit_o;

    int vectors    = 0;
    int miscompares = 0;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk            (clk),
        .rst            (rst),
        .wb_wdata       (wb_wdata),
        .wb_wd          (wb_wd),
        .wb_wreg        (wb_wreg),
        .wb_hi          (wb_hi),
        .wb_lo          (wb_lo),
        .wb_whilo       (wb_whilo),
        .wb_LLbit_we    (wb_LLbit_we),
        .wb_LLbit_value (wb_LLbit_value),
        .flush          (flush),
        .re1            (re1),
        .raddr1         (raddr1),
        .rdata1         (rdata1),
        .re2            (re2),
        .raddr2         (raddr2),
        .rdata2         (rdata2),
        .hi_o           (hi_o),
        .lo_o           (lo_o),
        .LLbit_o        (LLbit_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wd, input logic [31:0] wdata);
        wb_wreg  = we;
        wb_wd    = wd;
        wb_wdata = wdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b0;
        wb_wdata = '0; wb_wd = '0; wb_wreg = 1'b0;
        wb_hi = '0; wb_lo = '0; wb_whilo = 1'b0;
        wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; flush = 1'b0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;

        tick();
        checkOutput("reset_rdata1", rdata1, 32'h0);
        checkOutput("reset_hi", hi_o, 32'h0);
        checkOutput("reset_llbit", {31'b0, LLbit_o}, 32'h0);
        rst = 1'b1;

        // gpr[5] and HI/LO written in the same cycle
        wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
        applyStimulus(1'b1, 5'd5, 32'h1234);
        tick();
        wb_whilo = 1'b0; wb_hi = 32'h99; wb_lo = 32'h98;
        applyStimulus(1'b0, 5'd0, 32'h0);
        checkOutput("write_gpr5_port1", rdata1, 32'h1234);
        checkOutput("write_gpr5_port2", rdata2, 32'h1234);
        checkOutput("hilo_hi", hi_o, 32'h1);
        checkOutput("hilo_lo", lo_o, 32'h2);
        tick();
        checkOutput("hilo_hold_hi", hi_o, 32'h1);
        checkOutput("hilo_hold_lo", lo_o, 32'h2);

        // same-cycle HI/LO visibility
        wb_whilo = 1'b1; wb_hi = 32'h7; wb_lo = 32'h8;
        #1;
        checkOutput("hilo_bypass_hi", hi_o, BYPASS ? 32'h7 : 32'h1);
        tick();
        wb_whilo = 1'b0;
        checkOutput("hilo_new_hi", hi_o, 32'h7);
        checkOutput("hilo_new_lo", lo_o, 32'h8);

        // reset pulse between edges, with a write pending
        rst = 1'b0;
        #1;
        checkOutput("async_rst_rdata1", rdata1, 32'h0);
        checkOutput("async_rst_hi", hi_o, 32'h0);
        checkOutput("async_rst_lo", lo_o, 32'h0);
        applyStimulus(1'b1, 5'd5, 32'hFFFF_FFFF);
        checkOutput("rst_write_bypass_blocked", rdata1, 32'h0);
        tick();
        checkOutput("rst_write_ignored", rdata1, 32'h0);
        applyStimulus(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("post_rst_gpr5", rdata1, 32'h0);

        // writes to $0 are dropped
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        checkOutput("zero_reg_port1", rdata1, 32'h0);
        checkOutput("zero_reg_port2", rdata2, 32'h0);

        // same-cycle write/read of gpr[3]
        raddr1 = 5'd3; raddr2 = 5'd3;
        applyStimulus(1'b1, 5'd3, 32'hA5A5_A5A5);
        checkOutput("bypass_port1", rdata1, BYPASS ? 32'hA5A5_A5A5 : 32'h0);
        checkOutput("bypass_port2", rdata2, BYPASS ? 32'hA5A5_A5A5 : 32'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        checkOutput("after_edge_port1", rdata1, 32'hA5A5_A5A5);
        checkOutput("after_edge_port2", rdata2, 32'hA5A5_A5A5);

        // read-enable gating
        applyStimulus(1'b1, 5'd5, 32'h1234);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        raddr1 = 5'd5; re1 = 1'b0; raddr2 = 5'd5; re2 = 1'b1;
        #1;
        checkOutput("re1_off", rdata1, 32'h0);
        checkOutput("re2_on", rdata2, 32'h1234);
        re1 = 1'b1;
        #1;
        checkOutput("re1_on", rdata1, 32'h1234);

        // LLbit set, then flush overriding a simultaneous set
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        tick();
        wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0;
        #1;
        checkOutput("llbit_set", {31'b0, LLbit_o}, 32'h1);
        flush = 1'b1; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        #1;
        checkOutput("llbit_flush_bypass", {31'b0, LLbit_o}, BYPASS ? 32'h0 : 32'h1);
        tick();
        flush = 1'b0; wb_LLbit_we = 1'b0;
        #1;
        checkOutput("llbit_flushed", {31'b0, LLbit_o}, 32'h0);
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        tick();
        wb_LLbit_value = 1'b0;
        tick();
        wb_LLbit_we = 1'b0;
        #1;
        checkOutput("llbit_write_zero", {31'b0, LLbit_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
